// File: rtl/arm_pipelined_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// arm_pipelined_regfile_scoreboard
//
// Register file with N combinational read ports, one write port, R15 supplied
// from the PC path, same-cycle write-to-read bypass and a per-register
// pending-write scoreboard used by decode to detect RAW hazards.
//
// Ports:
//   i_CLK, i_RESET      clock (rising edge), synchronous active-high reset
//   i_ReadEnable        per-port read-valid mask
//   i_ReadAddr          packed read addresses, port 0 in LSBs
//   o_ReadData          packed read data, port 0 in LSBs (combinational)
//   i_R15               PC+8 value returned for PCRegIndex
//   i_IssueValid/Dest   decode issues an instruction writing Dest
//   o_IssueReady        issue accepted this cycle
//   i_WriteEnable/Addr/Data  writeback port
//   o_Hazard            OR of per-port RAW hazards (combinational)
//   o_PendingMask       bit r set when register r has in-flight writes
//   o_ScoreboardError   sticky underflow/saturation flag (only with
//                       ARM_SCOREBOARD_CHECK_EN defined)
//
// Optional feature macro: ARM_SCOREBOARD_CHECK_EN
// ---------------------------------------------------------------------------
module arm_pipelined_regfile_scoreboard #(
  parameter int BusWidth     = 32,
  parameter int RegAddrWidth = 4,
  parameter int NumReadPorts = 3,
  parameter int PCRegIndex   = 15,
  parameter int PendWidth    = 2
) (
  input  logic                               i_CLK,
  input  logic                               i_RESET,
  input  logic [NumReadPorts-1:0]            i_ReadEnable,
  input  logic [NumReadPorts*RegAddrWidth-1:0] i_ReadAddr,
  output logic [NumReadPorts*BusWidth-1:0]   o_ReadData,
  input  logic [BusWidth-1:0]                i_R15,
  input  logic                               i_IssueValid,
  input  logic [RegAddrWidth-1:0]            i_IssueDest,
  output logic                               o_IssueReady,
  input  logic                               i_WriteEnable,
  input  logic [RegAddrWidth-1:0]            i_WriteAddr,
  input  logic [BusWidth-1:0]                i_WriteData,
  output logic                               o_Hazard,
  output logic [2**RegAddrWidth-1:0]         o_PendingMask
`ifdef ARM_SCOREBOARD_CHECK_EN
  ,
  output logic                               o_ScoreboardError
`endif
);

  localparam int NumRegs = 2**RegAddrWidth;
  localparam logic [PendWidth-1:0]    PendMax  = {PendWidth{1'b1}};
  localparam logic [PendWidth-1:0]    PendZero = {PendWidth{1'b0}};
  localparam logic [PendWidth-1:0]    PendOne  = PendWidth'(1);
  localparam logic [RegAddrWidth-1:0] PcAddr   = RegAddrWidth'(PCRegIndex);

  logic [BusWidth-1:0]  regs_r      [NumRegs];
  logic [PendWidth-1:0] pend_r      [NumRegs];
  logic [PendWidth-1:0] pend_next_s [NumRegs];
  logic [NumRegs-1:0]   mask_r;
  logic [NumReadPorts-1:0] hazard_s;

  logic wr_reg_s;
  logic issue_reg_s;
  logic wb_same_s;
  logic issue_sat_s;
  logic issue_acc_s;
  logic underflow_s;

  // A write to the PC index has no storage and never touches a counter.
  assign wr_reg_s    = i_WriteEnable && (i_WriteAddr != PcAddr);
  assign issue_reg_s = i_IssueValid && (i_IssueDest != PcAddr);
  assign wb_same_s   = i_WriteEnable && (i_WriteAddr == i_IssueDest);
  // A full counter can still accept an issue when a writeback to the same
  // register frees a slot in the same cycle.
  assign issue_sat_s = issue_reg_s && (pend_r[i_IssueDest] == PendMax) && !wb_same_s;
  assign issue_acc_s = issue_reg_s && !issue_sat_s;
  assign underflow_s = wr_reg_s && (pend_r[i_WriteAddr] == PendZero);

  assign o_IssueReady  = !issue_sat_s;
  assign o_Hazard      = |hazard_s;
  assign o_PendingMask = mask_r;

  genvar p;
  for (p = 0; p < NumReadPorts; p++) begin : g_port
    logic [RegAddrWidth-1:0] addr_s;
    logic [BusWidth-1:0]     data_s;
    logic                    wr_hit_s;

    assign addr_s   = i_ReadAddr[p*RegAddrWidth +: RegAddrWidth];
    assign wr_hit_s = i_WriteEnable && (i_WriteAddr == addr_s);

    // Read mux: PC path first, then writeback bypass, then storage.
    always_comb begin
      data_s = regs_r[addr_s];
      if (addr_s == PcAddr) begin
        data_s = i_R15;
      end else if (wr_hit_s) begin
        data_s = i_WriteData;
      end else begin
        data_s = regs_r[addr_s];
      end
    end

    assign o_ReadData[p*BusWidth +: BusWidth] = data_s;

    // The last outstanding write arriving this cycle clears the hazard; with
    // two or more outstanding a younger writer is still pending.
    assign hazard_s[p] = i_ReadEnable[p] && (addr_s != PcAddr) &&
                         (pend_r[addr_s] != PendZero) &&
                         !((pend_r[addr_s] == PendOne) && wr_hit_s);
  end

  // Next pending count per register from accepted issues and retiring writes.
  always_comb begin
    for (int r = 0; r < NumRegs; r++) begin
      logic inc_s;
      logic dec_s;
      inc_s = issue_acc_s && (i_IssueDest == RegAddrWidth'(r));
      dec_s = wr_reg_s && (i_WriteAddr == RegAddrWidth'(r)) && (pend_r[r] != PendZero);
      case ({inc_s, dec_s})
        2'b10:   pend_next_s[r] = pend_r[r] + PendOne;
        2'b01:   pend_next_s[r] = pend_r[r] - PendOne;
        default: pend_next_s[r] = pend_r[r];
      endcase
    end
  end

  // Storage, pending counters and the registered pending mask.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      for (int r = 0; r < NumRegs; r++) begin
        regs_r[r] <= {BusWidth{1'b0}};
        pend_r[r] <= PendZero;
      end
      mask_r <= {NumRegs{1'b0}};
    end else begin
      if (wr_reg_s) begin
        regs_r[i_WriteAddr] <= i_WriteData;
      end
      for (int r = 0; r < NumRegs; r++) begin
        pend_r[r] <= pend_next_s[r];
        mask_r[r] <= (pend_next_s[r] != PendZero);
      end
    end
  end

`ifdef ARM_SCOREBOARD_CHECK_EN
  logic err_r;

  // Sticky flag for counter underflow or a saturation-rejected issue.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      err_r <= 1'b0;
    end else if (underflow_s || issue_sat_s) begin
      err_r <= 1'b1;
    end
  end

  assign o_ScoreboardError = err_r;
`else
  logic unused_s;
  assign unused_s = underflow_s;
`endif

endmodule

// File: tb/tb_arm_pipelined_regfile_scoreboard.sv
// Scoreboard bench: the driver computes expected outputs from a behavioural
// model and queues them; a monitor pops and compares after each drive.
module tb_arm_pipelined_regfile_scoreboard;
  localparam int BW = 32;
  localparam int AW = 4;
  localparam int NP = 3;
  localparam int NR = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     ren;
  logic [NP*AW-1:0]  raddr;
  logic [NP*BW-1:0]  rdata;
  logic [BW-1:0]     r15;
  logic              iv;
  logic [AW-1:0]     id;
  logic              irdy;
  logic              we;
  logic [AW-1:0]     wa;
  logic [BW-1:0]     wd;
  logic              hz;
  logic [NR-1:0]     pmask;
`ifdef ARM_SCOREBOARD_CHECK_EN
  logic              serr;
`endif

  always #5 clk = ~clk;

  arm_pipelined_regfile_scoreboard dut (
    .i_CLK(clk), .i_RESET(rst), .i_ReadEnable(ren), .i_ReadAddr(raddr),
    .o_ReadData(rdata), .i_R15(r15), .i_IssueValid(iv), .i_IssueDest(id),
    .o_IssueReady(irdy), .i_WriteEnable(we), .i_WriteAddr(wa),
    .i_WriteData(wd), .o_Hazard(hz), .o_PendingMask(pmask)
`ifdef ARM_SCOREBOARD_CHECK_EN
    , .o_ScoreboardError(serr)
`endif
  );

  typedef struct {
    logic [NP*BW-1:0] rd;
    logic             hz;
    logic             rdy;
    logic [NR-1:0]    mask;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event drv_ev;

  // Reference model state (value after the next clock edge once step returns).
  logic [BW-1:0] mem [NR];
  int            cnt [NR];
  logic          merr;

  function automatic logic [NP*AW-1:0] pk(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic cmp(input string name, input logic [NP*BW-1:0] act, input logic [NP*BW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, expv);
    end
  endtask

  task automatic step(input bit chk, input logic r, input logic [NP-1:0] en,
                      input logic [NP*AW-1:0] ra, input logic [BW-1:0] pc,
                      input logic ivv, input logic [AW-1:0] idd,
                      input logic wee, input logic [AW-1:0] waa, input logic [BW-1:0] wdd);
    exp_t        e;
    logic [AW-1:0] a;
    bit          ready;
    bit          decok;
    @(negedge clk);
    rst = r; ren = en; raddr = ra; r15 = pc; iv = ivv; id = idd;
    we = wee; wa = waa; wd = wdd;
    if (chk) begin
      e.hz = 1'b0;
      for (int p = 0; p < NP; p++) begin
        a = ra[p*AW +: AW];
        if (a == 4'd15)            e.rd[p*BW +: BW] = pc;
        else if (wee && waa == a)  e.rd[p*BW +: BW] = wdd;
        else                       e.rd[p*BW +: BW] = mem[a];
        if (en[p] && a != 4'd15 && cnt[a] > 0 && !(cnt[a] == 1 && wee && waa == a))
          e.hz = 1'b1;
      end
      e.rdy = !(ivv && idd != 4'd15 && cnt[idd] == 3 && !(wee && waa == idd));
      for (int k = 0; k < NR; k++) e.mask[k] = (cnt[k] != 0);
      e.err = merr;
      q.push_back(e);
      -> drv_ev;
    end
    if (r) begin
      for (int k = 0; k < NR; k++) begin mem[k] = '0; cnt[k] = 0; end
      merr = 1'b0;
    end else begin
      ready = !(ivv && idd != 4'd15 && cnt[idd] == 3 && !(wee && waa == idd));
      if (!ready) merr = 1'b1;
      decok = wee && waa != 4'd15 && cnt[waa] > 0;
      if (wee && waa != 4'd15 && cnt[waa] == 0) merr = 1'b1;
      if (wee && waa != 4'd15) mem[waa] = wdd;
      if (ivv && ready && idd != 4'd15) cnt[idd] = cnt[idd] + 1;
      if (decok) cnt[waa] = cnt[waa] - 1;
    end
  endtask

  // Monitor: pop one expectation per drive and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(drv_ev);
      #1;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty at %0t: actual=0 expected=1 entries", $time);
      end else begin
        e = q.pop_front();
        cmp("read_data", rdata, e.rd);
        cmp("hazard", {{(NP*BW-1){1'b0}}, hz}, {{(NP*BW-1){1'b0}}, e.hz});
        cmp("issue_ready", {{(NP*BW-1){1'b0}}, irdy}, {{(NP*BW-1){1'b0}}, e.rdy});
        cmp("pending_mask", {{(NP*BW-NR){1'b0}}, pmask}, {{(NP*BW-NR){1'b0}}, e.mask});
`ifdef ARM_SCOREBOARD_CHECK_EN
        cmp("sb_error", {{(NP*BW-1){1'b0}}, serr}, {{(NP*BW-1){1'b0}}, e.err});
`endif
      end
    end
  end

  initial begin
    logic [AW-1:0] ra0, ra1, ra2, rid, rwa;
    rst = 1'b0; ren = '0; raddr = '0; r15 = '0; iv = 1'b0; id = '0;
    we = 1'b0; wa = '0; wd = '0; merr = 1'b0;
    for (int k = 0; k < NR; k++) begin mem[k] = '0; cnt[k] = 0; end

    // Reset, then read every register; R15 comes from the PC input.
    step(0, 1, 3'b000, pk(0, 0, 0), 32'h0, 0, 4'd0, 0, 4'd0, 32'h0);
    for (int b = 0; b < 15; b += 3)
      step(1, 0, 3'b111, pk(b, b + 1, b + 2), 32'h0000_0108, 0, 4'd0, 0, 4'd0, 32'h0);
    step(1, 0, 3'b111, pk(15, 15, 15), 32'h0000_0108, 0, 4'd0, 0, 4'd0, 32'h0);

    // Bypass then stored value.
    step(1, 0, 3'b001, pk(3, 0, 0), 32'h108, 0, 4'd0, 1, 4'd3, 32'hDEAD_BEEF);
    step(1, 0, 3'b001, pk(3, 0, 0), 32'h108, 0, 4'd0, 0, 4'd0, 32'h0);

    // RAW hazard on R5, cleared by the writeback in the same cycle.
    step(1, 0, 3'b000, pk(5, 0, 0), 32'h108, 1, 4'd5, 0, 4'd0, 32'h0);
    step(1, 0, 3'b001, pk(5, 0, 0), 32'h108, 0, 4'd0, 0, 4'd0, 32'h0);
    step(1, 0, 3'b001, pk(5, 0, 0), 32'h108, 0, 4'd0, 1, 4'd5, 32'h11);
    step(1, 0, 3'b001, pk(5, 0, 0), 32'h108, 0, 4'd0, 0, 4'd0, 32'h0);

    // Double writer on R2.
    step(1, 0, 3'b000, pk(2, 0, 0), 32'h108, 1, 4'd2, 0, 4'd0, 32'h0);
    step(1, 0, 3'b000, pk(2, 0, 0), 32'h108, 1, 4'd2, 0, 4'd0, 32'h0);
    step(1, 0, 3'b010, pk(0, 2, 0), 32'h108, 0, 4'd0, 1, 4'd2, 32'h22);
    step(1, 0, 3'b010, pk(0, 2, 0), 32'h108, 0, 4'd0, 1, 4'd2, 32'h23);
    step(1, 0, 3'b010, pk(0, 2, 0), 32'h108, 0, 4'd0, 0, 4'd0, 32'h0);

    // Saturation on R7.
    for (int k = 0; k < 3; k++)
      step(1, 0, 3'b100, pk(0, 0, 7), 32'h108, 1, 4'd7, 0, 4'd0, 32'h0);
    step(1, 0, 3'b100, pk(0, 0, 7), 32'h108, 1, 4'd7, 0, 4'd0, 32'h0);
    step(1, 0, 3'b100, pk(0, 0, 7), 32'h108, 1, 4'd7, 1, 4'd7, 32'h77);
    for (int k = 0; k < 4; k++)
      step(1, 0, 3'b100, pk(0, 0, 7), 32'h108, 0, 4'd0, 1, 4'd7, 32'h70 + k);

    // PC issue, underflow write on R9, then reset clears everything.
    step(1, 0, 3'b000, pk(0, 0, 0), 32'h108, 1, 4'd15, 0, 4'd0, 32'h0);
    step(1, 0, 3'b001, pk(9, 0, 0), 32'h108, 0, 4'd0, 1, 4'd9, 32'h99);
    step(1, 0, 3'b001, pk(9, 0, 0), 32'h108, 0, 4'd0, 1, 4'd15, 32'h55);
    step(1, 1, 3'b001, pk(9, 0, 0), 32'h108, 1, 4'd9, 1, 4'd9, 32'h5);
    step(1, 0, 3'b111, pk(9, 7, 3), 32'h108, 0, 4'd0, 0, 4'd0, 32'h0);

    // Randomised traffic with a small address set to provoke hazards.
    for (int n = 0; n < 800; n++) begin
      ra0 = ($urandom_range(0, 5) == 0) ? 4'd15 : AW'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 5) == 0) ? 4'd15 : AW'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 5) == 0) ? 4'd15 : AW'($urandom_range(0, 7));
      rid = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 7));
      rwa = ($urandom_range(0, 7) == 0) ? 4'd15 : AW'($urandom_range(0, 7));
      step(1, ($urandom_range(0, 99) == 0), NP'($urandom), {ra2, ra1, ra0}, $urandom,
           ($urandom_range(0, 9) < 5), rid, ($urandom_range(0, 9) < 4), rwa, $urandom);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual=%0d expected=0 entries", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_pipelined_regfile_scoreboard.md
Name: arm_pipelined_regfile_scoreboard

Overview:
- Parametrised successor to the pipelined register file: N read ports, one write port, and R15 injected from the PC path.
- Same-cycle write-to-read bypass, so a writeback is visible to decode in the same cycle.
- Per-register pending-write scoreboard, so decode can detect RAW hazards on in-flight results and stall.
- Sits between decode (read/issue) and writeback (write); drives the hazard unit's stall input.

Parameters:
BusWidth, 32, data width of every register and port
RegAddrWidth, 4, register address width; NumRegs = 2**RegAddrWidth
NumReadPorts, 3, independent read ports (Rn, Rm, Rs/Rd)
PCRegIndex, 15, address that returns i_R15 and has no storage
PendWidth, 2, width of each pending-write counter; max in-flight writes per register = 2**PendWidth-1

Ports:
i_CLK  in  1  clock, rising edge
i_RESET  in  1  synchronous reset, active-high
i_ReadEnable  in  NumReadPorts  per-port read-valid mask; a disabled port never raises a hazard
i_ReadAddr  in  NumReadPorts*RegAddrWidth  packed read addresses, port 0 in LSBs
o_ReadData  out  NumReadPorts*BusWidth  packed read data, port 0 in LSBs
i_R15  in  BusWidth  PC+8 value returned for PCRegIndex
i_IssueValid  in  1  decode issues an instruction that will write i_IssueDest
i_IssueDest  in  RegAddrWidth  destination of the issued instruction
o_IssueReady  out  1  issue accepted this cycle
i_WriteEnable  in  1  writeback strobe
i_WriteAddr  in  RegAddrWidth  writeback destination
i_WriteData  in  BusWidth  writeback data
o_Hazard  out  1  OR over ports of per-port RAW hazard
o_PendingMask  out  2**RegAddrWidth  bit r = pending counter of r nonzero (registered state)

Behaviour:
- One clock i_CLK; reset synchronous, active-high on i_RESET.
- Reset: all registers 0, all pending counters 0, o_PendingMask 0, error flag 0. Reset has priority over a simultaneous write or issue.
- Reset mid-operation: in-flight writes are forgotten; writes arriving after reset deasserts still update storage but do not decrement the already-zero counters (underflow rule applies).
- Read, combinational per port p:
  - addr == PCRegIndex -> i_R15;
  - else i_WriteEnable && i_WriteAddr == addr -> i_WriteData (bypass);
  - else the stored value.
- Write: on the clock edge with i_WriteEnable, storage[i_WriteAddr] <= i_WriteData. A write to PCRegIndex is discarded.
- Issue:
  - o_IssueReady = !(i_IssueValid && i_IssueDest != PCRegIndex && counter[i_IssueDest] == max && !(writeback to the same register this cycle)).
  - An accepted issue to a non-PC register increments its counter.
  - Issue to PCRegIndex is always ready and has no counter effect.
- Counter update per register r, evaluated at the edge:
  - inc = accepted issue to r; dec = write to r with counter[r] != 0.
  - inc && dec -> unchanged; inc -> +1; dec -> -1.
  - Never wraps.
  - A write to r with counter 0 leaves it 0 (underflow).
- Hazard per port p:
  - ReadEnable[p] && addr != PCRegIndex && counter[addr] != 0 && !(counter[addr] == 1 && write to addr this cycle).
  - A counter of 2 or more with a write still hazards: a younger writer is pending.
- Issue and read in the same cycle: hazard is evaluated against the pre-issue counters, so an instruction never hazards on itself.
- Latency: read and hazard are 0 cycles; storage and counters update 1 edge later; o_PendingMask reflects state after the edge.

Optional Feature:
- Macro: ARM_SCOREBOARD_CHECK_EN.
- Defined:
  - Adds output o_ScoreboardError (1 bit), sticky, cleared only by i_RESET.
  - Set on the edge after either a write to a non-PC register whose counter is 0 (underflow) or an issue rejected by saturation.
- Undefined: port and logic absent; underflow and saturation are silently handled as above.

Test Plan:
- Reset then read: assert i_RESET 1 cycle; read R0..R14 -> all 0x00000000; read addr 15 with i_R15=0x00000108 -> 0x00000108; o_PendingMask=0.
- Bypass: write R3=0xDEADBEEF and read port0 addr 3 in the same cycle -> o_ReadData port0 = 0xDEADBEEF that cycle and from stored value next cycle.
- RAW hazard: issue dest R5 -> next cycle read R5 -> o_Hazard=1, o_PendingMask[5]=1. Write R5=0x11 with the read in the same cycle -> o_Hazard=0, data 0x11. Next cycle mask[5]=0.
- Double writer: issue R2 twice (counter 2), then write R2 while reading R2 -> o_Hazard=1. Second write while reading -> o_Hazard=0.
- Saturation: issue R7 three times, fourth issue -> o_IssueReady=0 and counter stays 3. Fourth issue concurrent with a write to R7 -> ready=1, counter stays 3. With ARM_SCOREBOARD_CHECK_EN, the rejected case sets o_ScoreboardError=1.
- PC and underflow: issue dest 15 -> ready=1, mask unchanged; write R9 with counter 0 -> R9 updated, mask[9]=0, o_ScoreboardError=1 when macro defined. i_RESET clears the error.
